// File: rtl/result_anim_pkg.sv
// Shared types and result code constants for the end-of-game result sequencer.
package result_anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ANIM = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int RES_NONE  = 0;
  localparam int RES_X_WIN = 1;
  localparam int RES_O_WIN = 2;
  localparam int RES_DRAW  = 3;

endpackage

// File: rtl/result_anim_sequencer_tick.sv
// Frame-rate enable generator: one-cycle tick every DIV enabled clk cycles.
module frame_tick_gen
  import result_anim_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Tick depends only on the count and enable, so clr can be derived from it upstream.
  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/result_anim_sequencer.sv
// Result presentation FSM: plays the per-result animation, then holds the banner.
// Optional feature macro: RESULT_BLINK_EN (blinking banner in HOLD).
module result_anim_sequencer
  import result_anim_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int FRAME_HZ = 6,
  parameter int N_FRAMES = 8,
  parameter int NUM_RES  = 4,
  localparam int RES_W    = $clog2(NUM_RES),
  localparam int FRAME_W  = $clog2(N_FRAMES),
  localparam int TICK_DIV = CLK_HZ / FRAME_HZ
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RES_W-1:0]          result,
  input  logic [12:0]               pixel_index,
  input  logic [(NUM_RES-1)*16-1:0] anim_pixel,
  input  logic [15:0]               banner_pixel,
  output logic [15:0]               oled_data,
  output logic [RES_W-1:0]          active_code,
  output logic [FRAME_W-1:0]        frame_idx,
  output logic                      busy,
  output logic                      done
);

  state_t               state, state_n;
  logic [RES_W-1:0]     code_n;
  logic [FRAME_W-1:0]   frame_n;
  logic                 done_n;
  logic                 tick_clr;
  logic                 tick_en;
  logic                 tick;
  logic [15:0]          anim_sel;
  logic [15:0]          oled_n;
  logic                 pixel_index_unused;

  // Sprite and banner streams arrive already aligned to pixel_index upstream.
  assign pixel_index_unused = ^pixel_index;

`ifdef RESULT_BLINK_EN
  logic blink, blink_n;
  assign tick_en = (state == ST_ANIM) || (state == ST_HOLD);
`else
  assign tick_en = (state == ST_ANIM);
`endif

  frame_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_n  = state;
    code_n   = active_code;
    frame_n  = frame_idx;
    done_n   = 1'b0;
    tick_clr = 1'b0;
`ifdef RESULT_BLINK_EN
    blink_n  = blink;
`endif
    if (result == RES_W'(RES_NONE)) begin
      // Abort wins over any pending tick/done.
      state_n  = ST_IDLE;
      code_n   = '0;
      frame_n  = '0;
      tick_clr = 1'b1;
`ifdef RESULT_BLINK_EN
      blink_n  = 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state_n  = ST_ANIM;
          code_n   = result;
          frame_n  = '0;
          tick_clr = 1'b1;
        end
        ST_ANIM: begin
          if (tick) begin
            if (frame_idx == FRAME_W'(N_FRAMES - 1)) begin
              state_n = ST_HOLD;
              done_n  = 1'b1;
`ifdef RESULT_BLINK_EN
              blink_n = 1'b0;
`endif
            end else begin
              frame_n = frame_idx + FRAME_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (result != active_code) begin
            state_n  = ST_ANIM;
            code_n   = result;
            frame_n  = '0;
            tick_clr = 1'b1;
          end
`ifdef RESULT_BLINK_EN
          else if (tick) begin
            blink_n = ~blink;
          end
`endif
        end
        default: begin
          state_n  = ST_IDLE;
          code_n   = '0;
          frame_n  = '0;
          tick_clr = 1'b1;
        end
      endcase
    end
  end

  // Pixel source follows the next-cycle state so oled_data lines up with busy/active_code.
  always_comb begin
    anim_sel = '0;
    for (int k = 1; k < NUM_RES; k++) begin
      if (code_n == RES_W'(k)) anim_sel = anim_pixel[(k-1)*16 +: 16];
    end
    oled_n = '0;
    case (state_n)
      ST_ANIM: oled_n = anim_sel;
`ifdef RESULT_BLINK_EN
      ST_HOLD: oled_n = blink_n ? 16'h0000 : banner_pixel;
`else
      ST_HOLD: oled_n = banner_pixel;
`endif
      default: oled_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      active_code <= '0;
      frame_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      oled_data   <= '0;
    end else begin
      state       <= state_n;
      active_code <= code_n;
      frame_idx   <= frame_n;
      busy        <= (state_n == ST_ANIM);
      done        <= done_n;
      oled_data   <= oled_n;
    end
  end

`ifdef RESULT_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink <= 1'b0;
    else        blink <= blink_n;
  end
`endif

endmodule

// File: tb/tb_result_anim_sequencer.sv
// Directed bench for result_anim_sequencer with a 10-clk frame tick and 4 frames.
module tb_result_anim_sequencer;
  import result_anim_pkg::*;

  localparam int CLK_HZ   = 60;
  localparam int FRAME_HZ = 6;
  localparam int N_FRAMES = 4;
  localparam int NUM_RES  = 4;

  localparam logic [15:0] PIX_X     = 16'h001F;
  localparam logic [15:0] PIX_O     = 16'h07E0;
  localparam logic [15:0] PIX_DRAW  = 16'hF800;
  localparam logic [15:0] PIX_BANNR = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  result = 2'd0;
  logic [12:0] pixel_index = 13'd0;
  logic [47:0] anim_pixel;
  logic [15:0] banner_pixel;
  logic [15:0] oled_data;
  logic [1:0]  active_code;
  logic [1:0]  frame_idx;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  result_anim_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .FRAME_HZ(FRAME_HZ),
    .N_FRAMES(N_FRAMES),
    .NUM_RES (NUM_RES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .result      (result),
    .pixel_index (pixel_index),
    .anim_pixel  (anim_pixel),
    .banner_pixel(banner_pixel),
    .oled_data   (oled_data),
    .active_code (active_code),
    .frame_idx   (frame_idx),
    .busy        (busy),
    .done        (done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) pixel_index <= (pixel_index == 13'd6143) ? 13'd0 : pixel_index + 13'd1;

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e_oled, input logic [1:0] e_code,
                            input logic [1:0] e_frame, input logic e_busy, input logic e_done);
    check_eq({tag, "_oled"},  32'(oled_data),   32'(e_oled));
    check_eq({tag, "_code"},  32'(active_code), 32'(e_code));
    check_eq({tag, "_frame"}, 32'(frame_idx),   32'(e_frame));
    check_eq({tag, "_busy"},  32'(busy),        32'(e_busy));
    check_eq({tag, "_done"},  32'(done),        32'(e_done));
  endtask

  // Drivers (inputs change on the falling edge)
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_result(input logic [1:0] v);
    result = v;
  endtask

  initial begin
    anim_pixel   = {PIX_DRAW, PIX_O, PIX_X};
    banner_pixel = PIX_BANNR;

    // Reset state
    wait_cycles(2);
    check_outs("reset", 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    wait_cycles(2);
    check_outs("idle", 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Full animation of X win
    drive_result(2'(RES_X_WIN));
    wait_cycles(1);
    check_outs("a_start", PIX_X, 2'd1, 2'd0, 1'b1, 1'b0);
    wait_cycles(9);
    check_outs("a_f0_end", PIX_X, 2'd1, 2'd0, 1'b1, 1'b0);
    wait_cycles(1);
    check_outs("a_f1", PIX_X, 2'd1, 2'd1, 1'b1, 1'b0);
    wait_cycles(10);
    check_eq("a_f2", 32'(frame_idx), 32'd2);
    wait_cycles(10);
    check_eq("a_f3", 32'(frame_idx), 32'd3);
    wait_cycles(9);
    check_outs("a_pre_done", PIX_X, 2'd1, 2'd3, 1'b1, 1'b0);
    wait_cycles(1);
    check_outs("a_done", PIX_BANNR, 2'd1, 2'd3, 1'b0, 1'b1);
    wait_cycles(1);
    check_outs("a_hold", PIX_BANNR, 2'd1, 2'd3, 1'b0, 1'b0);
`ifdef RESULT_BLINK_EN
    wait_cycles(9);
    check_eq("blink_off", 32'(oled_data), 32'h0);
    wait_cycles(10);
    check_eq("blink_on", 32'(oled_data), 32'(PIX_BANNR));
`else
    wait_cycles(19);
    check_eq("hold_steady", 32'(oled_data), 32'(PIX_BANNR));
`endif

    // Restart from HOLD with a different code, then a glitch to another code
    drive_result(2'(RES_DRAW));
    wait_cycles(1);
    check_outs("b_restart", PIX_DRAW, 2'd3, 2'd0, 1'b1, 1'b0);
    wait_cycles(4);
    drive_result(2'(RES_O_WIN));
    wait_cycles(1);
    check_outs("b_glitch", PIX_DRAW, 2'd3, 2'd0, 1'b1, 1'b0);
    wait_cycles(2);
    drive_result(2'(RES_DRAW));
    wait_cycles(32);
    check_outs("b_pre_done", PIX_DRAW, 2'd3, 2'd3, 1'b1, 1'b0);
    wait_cycles(1);
    check_outs("b_done", PIX_BANNR, 2'd3, 2'd3, 1'b0, 1'b1);

    // Abort at frame 2
    drive_result(2'(RES_O_WIN));
    wait_cycles(1);
    check_outs("c_start", PIX_O, 2'd2, 2'd0, 1'b1, 1'b0);
    wait_cycles(20);
    check_eq("c_f2", 32'(frame_idx), 32'd2);
    drive_result(2'(RES_NONE));
    wait_cycles(1);
    check_outs("c_abort", 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_cycles(5);
      check_eq("c_no_done", 32'(done), 32'd0);
    end

    // Re-entry clears the tick counter
    drive_result(2'(RES_X_WIN));
    wait_cycles(1);
    check_outs("d_start", PIX_X, 2'd1, 2'd0, 1'b1, 1'b0);
    wait_cycles(9);
    check_eq("d_f0_end", 32'(frame_idx), 32'd0);
    wait_cycles(1);
    check_eq("d_f1", 32'(frame_idx), 32'd1);

    // Asynchronous reset mid-animation
    wait_cycles(3);
    #2 rst_n = 1'b0;
    #1 check_outs("e_async", 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    wait_cycles(1);
    drive_result(2'(RES_NONE));
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);
    check_outs("e_idle", 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
